gray_ptr_rx: RTL and testbench

- Receive-side consumer of a 4-bit (parameterisable) Gray-coded pointer or counter, as produced by the binary-to-Gray encoder stage.
- Synchronises the Gray word into the local clock domain with a 2-flop synchroniser and converts it back to binary.
- Classifies each change as increment, decrement or illegal (more than one bit flipped), and keeps sticky and counted error status.
- Sits at the destination end of a Gray-coded crossing, for example the pointer comparison in an async FIFO.

---
 rtl/gray_ptr_rx.sv | 142 ++++++++++++++
 tb/tb_gray_ptr_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_rx.sv
// Receive side of a Gray-coded pointer crossing: 2-flop synchroniser, Gray-to-binary
// conversion, and inc/dec/illegal-change classification with sticky and counted errors.
module gray_ptr_rx #(
  parameter int W   = 4,
  parameter int ECW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   gray_in,
  input  logic           err_clr,
  output logic [W-1:0]   bin_out,
  output logic           bin_valid,
  output logic           inc,
  output logic           dec,
  output logic           err,
  output logic           err_sticky,
  output logic [ECW-1:0] err_cnt
);

  typedef enum logic {INIT, TRACK} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     sync1_reg, sync2_reg;
  logic             fill1_reg, fill2_reg;
  logic [W-1:0]     prev_gray_reg, prev_gray_next;
  logic [W-1:0]     bin_reg, bin_next;
  logic             valid_reg, valid_next;
  logic             inc_reg, inc_next;
  logic             dec_reg, dec_next;
  logic             err_reg, err_next;
  logic             sticky_reg, sticky_next;
  logic [ECW-1:0]   cnt_reg, cnt_next;

  logic [W-1:0]     conv_new, conv_prev, diff;
  logic             no_change, multi_change;

  // Binary bit i is the XOR of all Gray bits from the MSB down to i.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_conv
      assign conv_new[gi]  = ^sync2_reg[W-1:gi];
      assign conv_prev[gi] = ^prev_gray_reg[W-1:gi];
    end
  endgenerate

  assign diff         = sync2_reg ^ prev_gray_reg;
  assign no_change    = (diff == '0);
  assign multi_change = ((diff & (diff - W'(1))) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      sync1_reg     <= '0;
      sync2_reg     <= '0;
      fill1_reg     <= 1'b0;
      fill2_reg     <= 1'b0;
      prev_gray_reg <= '0;
      bin_reg       <= '0;
      valid_reg     <= 1'b0;
      inc_reg       <= 1'b0;
      dec_reg       <= 1'b0;
      err_reg       <= 1'b0;
      sticky_reg    <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      sync1_reg     <= gray_in;
      sync2_reg     <= sync1_reg;
      fill1_reg     <= 1'b1;
      fill2_reg     <= fill1_reg;
      prev_gray_reg <= prev_gray_next;
      bin_reg       <= bin_next;
      valid_reg     <= valid_next;
      inc_reg       <= inc_next;
      dec_reg       <= dec_next;
      err_reg       <= err_next;
      sticky_reg    <= sticky_next;
      cnt_reg       <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_gray_next = prev_gray_reg;
    bin_next       = bin_reg;
    valid_next     = valid_reg;
    inc_next       = 1'b0;
    dec_next       = 1'b0;
    err_next       = 1'b0;
    sticky_next    = sticky_reg;
    cnt_next       = cnt_reg;

    if (err_clr) begin
      sticky_next = 1'b0;
      cnt_next    = '0;
    end

    case (state_reg)
      // Baseline is taken only once sync2 holds a real sample, not its reset zero,
      // so reset release never looks like a jump from 0.
      INIT: begin
        if (fill2_reg) begin
          prev_gray_next = sync2_reg;
          bin_next       = conv_new;
          valid_next     = 1'b1;
          state_next     = TRACK;
        end
      end
      TRACK: begin
        if (!no_change) begin
          prev_gray_next = sync2_reg;
          if (multi_change) begin
            err_next    = 1'b1;
            sticky_next = 1'b1;
            if (err_clr)
              cnt_next = ECW'(1);
            else if (cnt_reg != '1)
              cnt_next = cnt_reg + ECW'(1);
          end else begin
            bin_next = conv_new;
            // Direction is judged against the Gray baseline, which after an error
            // differs from the held bin_out.
            if (conv_new == conv_prev + W'(1))
              inc_next = 1'b1;
            else
              dec_next = 1'b1;
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign bin_out    = bin_reg;
  assign bin_valid  = valid_reg;
  assign inc        = inc_reg;
  assign dec        = dec_reg;
  assign err        = err_reg;
  assign err_sticky = sticky_reg;
  assign err_cnt    = cnt_reg;

endmodule

// File: tb/tb_gray_ptr_rx.sv
// Directed bench for gray_ptr_rx: table of Gray steps with expected classification,
// plus hand sequences for reset, mid-stream reset and error-counter saturation.
module tb_gray_ptr_rx;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       err_clr;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic       inc;
  logic       dec;
  logic       err;
  logic       err_sticky;
  logic [7:0] err_cnt;

  gray_ptr_rx #(.W(4), .ECW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .gray_in   (gray_in),
    .err_clr   (err_clr),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .inc       (inc),
    .dec       (dec),
    .err       (err),
    .err_sticky(err_sticky),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gray;
    logic       clr;
    logic [3:0] bin;
    logic       inc;
    logic       dec;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
  } vec_t;

  localparam int NVEC = 20;
  localparam int NSAT = 259;

  vec_t       vecs [NVEC];
  int         checks = 0;
  int         errors = 0;
  int         n_inc = 0, n_dec = 0, n_err = 0;
  logic [3:0] exp_bin_prev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (inc) n_inc++;
      if (dec) n_dec++;
      if (err) n_err++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bin_out"}, 32'(bin_out), 0);
    chk({tag, "_bin_valid"}, 32'(bin_valid), 0);
    chk({tag, "_pulses"}, 32'({inc, dec, err}), 0);
    chk({tag, "_sticky"}, 32'(err_sticky), 0);
    chk({tag, "_cnt"}, 32'(err_cnt), 0);
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    v = vecs[i];
    gray_in = v.gray;
    err_clr = 1'b0;
    step();                                   // E0: sample in sync1
    step();                                   // E1: sample in sync2, outputs still old
    chk("e1_bin_hold", 32'(bin_out), 32'(exp_bin_prev));
    chk("e1_no_pulse", 32'({inc, dec, err}), 0);
    err_clr = v.clr;
    step();                                   // E2: result registered
    err_clr = 1'b0;
    chk("e2_bin", 32'(bin_out), 32'(v.bin));
    chk("e2_inc", 32'(inc), 32'(v.inc));
    chk("e2_dec", 32'(dec), 32'(v.dec));
    chk("e2_err", 32'(err), 32'(v.err));
    chk("e2_sticky", 32'(err_sticky), 32'(v.sticky));
    chk("e2_cnt", 32'(err_cnt), 32'(v.cnt));
    chk("e2_valid", 32'(bin_valid), 1);
    $display("vec %0d gray=%b clr=%b bin=%0d inc=%b dec=%b err=%b sticky=%b cnt=%0d",
             i, v.gray, v.clr, bin_out, inc, dec, err, err_sticky, err_cnt);
    step();                                   // E3: pulses last one cycle only
    chk("e3_pulse_gone", 32'({inc, dec, err}), 0);
    exp_bin_prev = v.bin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int exp_inc, exp_dec, exp_err;

    //                gray     clr   bin    inc   dec   err   stk   cnt
    vecs[0]  = '{4'b0010, 1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{4'b0001, 1'b0, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{4'b0001, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{4'b0011, 1'b0, 4'd2,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{4'b0010, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{4'b0110, 1'b0, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{4'b0010, 1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{4'b0011, 1'b0, 4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{4'b0001, 1'b0, 4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{4'b0000, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{4'b1000, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{4'b0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{4'b0011, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[15] = '{4'b0010, 1'b0, 4'd3,  1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    vecs[16] = '{4'b0111, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 8'd1};
    vecs[17] = '{4'b0111, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[18] = '{4'b0110, 1'b0, 4'd4,  1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[19] = '{4'b0111, 1'b0, 4'd5,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    exp_inc = 0;
    exp_dec = 0;
    exp_err = NSAT;
    for (int i = 0; i < NVEC; i++) begin
      exp_inc += int'(vecs[i].inc);
      exp_dec += int'(vecs[i].dec);
      exp_err += int'(vecs[i].err);
    end

    // Reset held with a non-zero Gray input, then baseline on release
    rst_n   = 1'b0;
    gray_in = 4'b0110;
    err_clr = 1'b0;
    step();
    step();
    step();
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    step();
    chk("init_e0_valid", 32'(bin_valid), 0);
    step();
    chk("init_e1_valid", 32'(bin_valid), 0);
    step();
    chk("init_bin", 32'(bin_out), 4);
    chk("init_valid", 32'(bin_valid), 1);
    chk("init_pulses", 32'({inc, dec, err}), 0);
    $display("baseline gray=%b bin=%0d valid=%b", gray_in, bin_out, bin_valid);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_pulses", 32'({inc, dec, err}), 0);
    end
    exp_bin_prev = 4'd4;

    for (int i = 0; i < NVEC; i++) apply_vec(i);

    // Mid-stream reset must clear outputs without waiting for a clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    $display("mid-stream reset bin=%0d valid=%b cnt=%0d", bin_out, bin_valid, err_cnt);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rebase_e1_valid", 32'(bin_valid), 0);
    step();
    chk("rebase_bin", 32'(bin_out), 5);
    chk("rebase_valid", 32'(bin_valid), 1);
    chk("rebase_pulses", 32'({inc, dec, err}), 0);
    step();
    chk("rebase_hold_pulses", 32'({inc, dec, err}), 0);
    $display("rebaseline gray=%b bin=%0d", gray_in, bin_out);

    // Every step below flips three bits: one illegal change per cycle
    for (int i = 0; i < NSAT; i++) begin
      gray_in = (i % 2 == 0) ? 4'b0000 : 4'b0111;
      step();
    end
    step();
    step();
    step();
    chk("sat_cnt", 32'(err_cnt), 255);
    chk("sat_sticky", 32'(err_sticky), 1);
    chk("sat_bin", 32'(bin_out), 5);
    chk("sat_err_idle", 32'(err), 0);
    $display("saturation jumps=%0d cnt=%0d sticky=%b", NSAT, err_cnt, err_sticky);

    step();
    chk("total_inc", 32'(n_inc), 32'(exp_inc));
    chk("total_dec", 32'(n_dec), 32'(exp_dec));
    chk("total_err", 32'(n_err), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
